load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request, performs read or
// read-modify-write on a word memory, and returns a single response.
module load_store_unit #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_next;
   logic        write_q, unsigned_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, data_q;
   logic        req_err;
   logic [4:0]  shamt;
   logic [31:0] lane, load_val, lane_mask, store_word, word_addr;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         2'b01:   req_err = req_addr[0];
         2'b10:   req_err = |req_addr[1:0];
         2'b11:   req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
      if (req_addr >= ADDR_LIMIT)
         req_err = 1'b1;
   end

   // Half accesses are 2-byte aligned, so the byte-offset shift also selects the half lane.
   assign shamt     = {addr_q[1:0], 3'b000};
   assign word_addr = {addr_q[31:2], 2'b00};
   assign lane      = mem_dout >> shamt;

   always_comb begin
      load_val  = mem_dout;
      lane_mask = 32'hFFFF_FFFF;
      case (size_q)
         2'b00: begin
            load_val  = unsigned_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            lane_mask = 32'h0000_00FF << shamt;
         end
         2'b01: begin
            load_val  = unsigned_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            lane_mask = 32'h0000_FFFF << shamt;
         end
         default: begin
            load_val  = mem_dout;
            lane_mask = 32'hFFFF_FFFF;
         end
      endcase
   end

   assign store_word = (size_q == 2'b10) ? wdata_q
                     : ((data_q & ~lane_mask) | ((wdata_q << shamt) & lane_mask));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         data_q     <= 32'h0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (req_valid) begin
               write_q    <= req_write;
               size_q     <= req_size;
               unsigned_q <= req_unsigned;
               addr_q     <= req_addr;
               wdata_q    <= req_wdata;
               err_q      <= req_err;
               data_q     <= 32'h0;
            end
            // data_q holds the load result, or the old word for a partial store merge.
            RD:      data_q <= write_q ? mem_dout : load_val;
            WR:      data_q <= 32'h0;
            default: data_q <= data_q;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_err   = 1'b0;
      mem_addr   = 32'h0;
      mem_din    = 32'h0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = reset;
            if (req_valid) begin
               if (req_err)
                  state_next = RESP;
               else if (req_write && req_size == 2'b10)
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD: begin
            mem_read   = 1'b1;
            mem_addr   = word_addr;
            state_next = write_q ? WR : RESP;
         end
         WR: begin
            mem_write  = 1'b1;
            mem_addr   = word_addr;
            mem_din    = store_word;
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = data_q;
            resp_err   = err_q;
            if (resp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        resp_ready = 1'b0;
   logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
   logic [31:0] mem [0:255];

   int checks = 0, failures = 0;
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, din_rd_bad = 0;
   logic [31:0] wr_addr_seen = 32'h0, wr_din_seen = 32'h0;

   load_store_unit #(.ADDR_LIMIT(32'h0001_0000)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr[9:2]];

   always @(posedge clk)
      if (mem_write) mem[mem_addr[9:2]] <= mem_din;

   // Memory-side activity seen during each request, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
         wr_cnt++;
         wr_addr_seen = mem_addr;
         wr_din_seen  = mem_din;
      end
      if (mem_read && mem_write) both_cnt++;
      if (mem_read && mem_din != 32'h0) din_rd_bad++;
   end

   task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
      @(posedge clk); #1;
      rd_cnt = 0; wr_cnt = 0;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_unsigned = ~uns;
      lat = 99; rdata = 32'h0; err = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = i; rdata = resp_rdata; err = resp_err;
            break;
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready actual=%b required=0", req_ready); end
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp actual=%b/%b/%h required=0/0/0", resp_valid, resp_err, resp_rdata); end
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_din !== 32'h0) begin failures++; $display("FAIL rst_mem actual=%b/%b/%h/%h required=0", mem_read, mem_write, mem_addr, mem_din); end
      @(negedge clk); #2 reset = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready actual=%b required=1", req_ready); end
   endtask

   task automatic test_word_store_load();
      int lat; logic [31:0] rd; logic er;
      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
      checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency actual=%0d required=2", lat); end
      checks++; if (wr_cnt !== 1 || rd_cnt !== 0) begin failures++; $display("FAIL sw_mem_cycles actual=wr%0d/rd%0d required=wr1/rd0", wr_cnt, rd_cnt); end
      checks++; if (wr_addr_seen !== 32'h10 || wr_din_seen !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_mem_bus actual=%h/%h required=00000010/deadbeef", wr_addr_seen, wr_din_seen); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sw_resp actual=%h/%b required=0/0", rd, er); end
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
      checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency actual=%0d required=2", lat); end
      checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin failures++; $display("FAIL lw_data actual=%h/%b required=deadbeef/0", rd, er); end
      checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin failures++; $display("FAIL lw_mem_cycles actual=rd%0d/wr%0d required=rd1/wr0", rd_cnt, wr_cnt); end
   endtask

   task automatic test_partial_load();
      int lat; logic [31:0] rd; logic er;
      logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
      logic        uns [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] ad  [5] = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h10};
      logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_80FF};
      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_80FF, lat, rd, er);
      for (int i = 0; i < 5; i++) begin
         run_req(1'b0, sz[i], uns[i], ad[i], 32'h0, lat, rd, er);
         checks++; if (rd !== exp[i] || er !== 1'b0 || lat !== 2) begin failures++; $display("FAIL part_load_%0d actual=%h/err%b/lat%0d required=%h/err0/lat2", i, rd, er, lat, exp[i]); end
      end
   endtask

   task automatic test_partial_store();
      int lat; logic [31:0] rd; logic er;
      run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AB, lat, rd, er);
      checks++; if (lat !== 3) begin failures++; $display("FAIL sb_latency actual=%0d required=3", lat); end
      checks++; if (rd_cnt !== 1 || wr_cnt !== 1) begin failures++; $display("FAIL sb_mem_cycles actual=rd%0d/wr%0d required=rd1/wr1", rd_cnt, wr_cnt); end
      checks++; if (wr_addr_seen !== 32'h10 || wr_din_seen !== 32'hAB34_80FF) begin failures++; $display("FAIL sb_mem_bus actual=%h/%h required=00000010/ab3480ff", wr_addr_seen, wr_din_seen); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sb_resp actual=%h/%b required=0/0", rd, er); end
      run_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF_5555, lat, rd, er);
      checks++; if (mem[4] !== 32'hAB34_5555 || lat !== 3) begin failures++; $display("FAIL sh_merge actual=%h/lat%0d required=ab345555/lat3", mem[4], lat); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er;
      logic        wr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0]  sz [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
      logic [31:0] ad [5] = '{32'h11, 32'h12, 32'h10, 32'h0001_0000, 32'h0001_0000};
      for (int i = 0; i < 5; i++) begin
         run_req(wr[i], sz[i], 1'b0, ad[i], 32'h5A5A_5A5A, lat, rd, er);
         checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin failures++; $display("FAIL err_case_%0d actual=err%b/%h/lat%0d/rd%0d/wr%0d required=err1/0/lat1/rd0/wr0", i, er, rd, lat, rd_cnt, wr_cnt); end
      end
      run_req(1'b1, 2'b10, 1'b0, 32'h0000_FFFC, 32'hCAFE_F00D, lat, rd, er);
      run_req(1'b0, 2'b10, 1'b0, 32'h0000_FFFC, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin failures++; $display("FAIL limit_edge actual=%h/%b required=cafef00d/0", rd, er); end
   endtask

   task automatic test_back_pressure();
      logic ok;
      @(posedge clk); #1;
      rd_cnt = 0; wr_cnt = 0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_1111;
      @(negedge clk); @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hAB34_5555 || resp_err !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
      end
      checks++; if (!ok) begin failures++; $display("FAIL bp_hold actual=%b/%h/%b required=1/ab345555/0", resp_valid, resp_rdata, req_ready); end
      checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin failures++; $display("FAIL bp_mem_quiet actual=rd%0d/wr%0d required=rd1/wr0", rd_cnt, wr_cnt); end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0; req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release actual=%b/%b required=0/1", resp_valid, req_ready); end
   endtask

   task automatic test_reset_mid_write();
      int lat; logic [31:0] rd; logic er;
      run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h1122_3344, lat, rd, er);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h15; req_wdata = 32'h77;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rmw_in_wr actual=%b required=1", mem_write); end
      #1 reset = 1'b0;
      #1;
      checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 32'h0 || mem_din !== 32'h0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rmw_reset_outs actual=%b/%b/%h/%h/%b/%b required=all0", mem_write, mem_read, mem_addr, mem_din, req_ready, resp_valid); end
      @(posedge clk); #1;
      checks++; if (mem[5] !== 32'h1122_3344) begin failures++; $display("FAIL rmw_no_write actual=%h required=11223344", mem[5]); end
      @(negedge clk); reset = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmw_release_ready actual=%b required=1", req_ready); end
      run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'h1122_3344 || lat !== 2) begin failures++; $display("FAIL rmw_after actual=%h/lat%0d required=11223344/lat2", rd, lat); end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_partial_load();
      test_partial_store();
      test_errors();
      test_back_pressure();
      test_reset_mid_write();
      checks++; if (both_cnt !== 0 || din_rd_bad !== 0) begin failures++; $display("FAIL mem_exclusive actual=both%0d/dinrd%0d required=0/0", both_cnt, din_rd_bad); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
